// File: rtl/snapshot_mem_arbiter.sv
// Round-robin arbiter serialising one-cycle snapshot window requests onto a single
// shared entry memory port, with a per-access watchdog so a hung memory cannot stall software.
module snapshot_mem_arbiter #(
   parameter int REQ_CNT     = 4,
   parameter int ENTRY_WIDTH = 7,
   parameter int MEM_WIDTH   = 36,
   parameter int TIMEOUT     = 255,
   parameter int TO_WIDTH    = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [REQ_CNT-1:0]               req_mem_req_vld,
   input  logic [REQ_CNT*ENTRY_WIDTH-1:0]   req_mem_addr,
   input  logic [REQ_CNT-1:0]               req_mem_rd_en,
   input  logic [REQ_CNT-1:0]               req_mem_wr_en,
   input  logic [REQ_CNT*MEM_WIDTH-1:0]     req_mem_wr_data,
   output logic [REQ_CNT-1:0]               req_mem_ack_vld,
   output logic [MEM_WIDTH-1:0]             req_mem_rd_data,
   output logic                             mem_req_vld,
   output logic [ENTRY_WIDTH-1:0]           mem_addr,
   output logic                             mem_rd_en,
   output logic                             mem_wr_en,
   output logic [MEM_WIDTH-1:0]             mem_wr_data,
   input  logic [MEM_WIDTH-1:0]             mem_rd_data,
   input  logic                             mem_ack_vld,
   output logic                             busy,
   output logic [$clog2(REQ_CNT)-1:0]       grant_id,
   output logic                             timeout_err
);

   localparam int GW = $clog2(REQ_CNT);
   localparam logic [TO_WIDTH:0] TO_LIMIT = (TO_WIDTH+1)'(TIMEOUT);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_ISSUE = 4'b0010,
      S_WAIT  = 4'b0100,
      S_RESP  = 4'b1000
   } state_t;

   state_t                 state_reg;
   logic [REQ_CNT-1:0]     pending_reg;
   logic [REQ_CNT-1:0]     pending_next;
   logic [REQ_CNT-1:0]     clr_vec;
   logic [GW-1:0]          ptr_reg;
   logic [GW-1:0]          grant_reg;
   logic                   mem_req_vld_reg;
   logic [ENTRY_WIDTH-1:0] mem_addr_reg;
   logic                   mem_rd_en_reg;
   logic                   mem_wr_en_reg;
   logic [MEM_WIDTH-1:0]   mem_wr_data_reg;
   logic [MEM_WIDTH-1:0]   rd_data_reg;
   logic [REQ_CNT-1:0]     ack_reg;
   logic                   to_err_reg;
   logic [TO_WIDTH-1:0]    wd_reg;
   logic [TO_WIDTH:0]      wd_inc;
   logic                   timeout_hit;
   logic                   mem_done;

   logic [ENTRY_WIDTH-1:0] addr_arr  [REQ_CNT];
   logic [MEM_WIDTH-1:0]   wdata_arr [REQ_CNT];

   logic                   gnt_found;
   logic [GW-1:0]          gnt_idx;
   logic [GW-1:0]          cand;

   function automatic logic [REQ_CNT-1:0] to_onehot(input logic [GW-1:0] idx);
      logic [REQ_CNT-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign clr_vec = (state_reg == S_RESP) ? to_onehot(grant_reg) : '0;

   // A new pulse always sets the bit, even in the cycle its previous access retires.
   genvar gi;
   generate
      for (gi = 0; gi < REQ_CNT; gi++) begin : g_req
         assign addr_arr[gi]     = req_mem_addr[gi*ENTRY_WIDTH +: ENTRY_WIDTH];
         assign wdata_arr[gi]    = req_mem_wr_data[gi*MEM_WIDTH +: MEM_WIDTH];
         assign pending_next[gi] = req_mem_req_vld[gi] | (pending_reg[gi] & ~clr_vec[gi]);
      end
   endgenerate

   // Search starts just above the last winner so every requester gets a turn.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= REQ_CNT; k++) begin
         cand = GW'((int'(ptr_reg) + k) % REQ_CNT);
         if (!gnt_found && pending_reg[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign wd_inc      = {1'b0, wd_reg} + (TO_WIDTH+1)'(1);
   assign timeout_hit = (TIMEOUT != 0) && (state_reg == S_WAIT) && (wd_inc >= TO_LIMIT);
   assign mem_done    = mem_ack_vld || timeout_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         pending_reg     <= '0;
         ptr_reg         <= GW'(REQ_CNT-1);
         grant_reg       <= '0;
         mem_req_vld_reg <= 1'b0;
         mem_addr_reg    <= '0;
         mem_rd_en_reg   <= 1'b0;
         mem_wr_en_reg   <= 1'b0;
         mem_wr_data_reg <= '0;
         rd_data_reg     <= '0;
         ack_reg         <= '0;
         to_err_reg      <= 1'b0;
         wd_reg          <= '0;
      end else begin
         pending_reg     <= pending_next;
         ack_reg         <= '0;
         to_err_reg      <= 1'b0;
         mem_req_vld_reg <= 1'b0;
         unique case (state_reg)
            S_IDLE: begin
               if (gnt_found) begin
                  grant_reg <= gnt_idx;
                  if (req_mem_rd_en[gnt_idx] || req_mem_wr_en[gnt_idx]) begin
                     mem_req_vld_reg <= 1'b1;
                     mem_addr_reg    <= addr_arr[gnt_idx];
                     mem_rd_en_reg   <= req_mem_rd_en[gnt_idx];
                     mem_wr_en_reg   <= req_mem_wr_en[gnt_idx];
                     mem_wr_data_reg <= wdata_arr[gnt_idx];
                     state_reg       <= S_ISSUE;
                  end else begin
                     // Nothing to do at the memory: complete straight away.
                     ack_reg   <= to_onehot(gnt_idx);
                     state_reg <= S_RESP;
                  end
               end
            end
            S_ISSUE, S_WAIT: begin
               if (state_reg == S_ISSUE) begin
                  wd_reg <= '0;
               end else if (wd_reg != {TO_WIDTH{1'b1}}) begin
                  wd_reg <= wd_inc[TO_WIDTH-1:0];
               end
               if (mem_done) begin
                  if (mem_ack_vld) begin
                     if (mem_rd_en_reg) begin
                        rd_data_reg <= mem_rd_data;
                     end
                  end else begin
                     rd_data_reg <= '0;
                     to_err_reg  <= 1'b1;
                  end
                  ack_reg         <= to_onehot(grant_reg);
                  mem_addr_reg    <= '0;
                  mem_rd_en_reg   <= 1'b0;
                  mem_wr_en_reg   <= 1'b0;
                  mem_wr_data_reg <= '0;
                  state_reg       <= S_RESP;
               end else begin
                  state_reg <= S_WAIT;
               end
            end
            S_RESP: begin
               ptr_reg   <= grant_reg;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign req_mem_ack_vld = ack_reg;
   assign req_mem_rd_data = rd_data_reg;
   assign mem_req_vld     = mem_req_vld_reg;
   assign mem_addr        = mem_addr_reg;
   assign mem_rd_en       = mem_rd_en_reg;
   assign mem_wr_en       = mem_wr_en_reg;
   assign mem_wr_data     = mem_wr_data_reg;
   assign busy            = (state_reg != S_IDLE);
   assign grant_id        = grant_reg;
   assign timeout_err     = to_err_reg;

endmodule

// File: tb/tb_snapshot_mem_arbiter.sv
// Randomised bench for snapshot_mem_arbiter: a transaction-level round-robin model predicts
// grant order, per-access latency, read data and timeouts against a behavioural memory.
module tb_snapshot_mem_arbiter;
   localparam int N  = 4;
   localparam int EW = 7;
   localparam int MW = 36;
   localparam int TO = 4;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]    req_mem_req_vld = '0;
   logic [N*EW-1:0] req_mem_addr = '0;
   logic [N-1:0]    req_mem_rd_en = '0;
   logic [N-1:0]    req_mem_wr_en = '0;
   logic [N*MW-1:0] req_mem_wr_data = '0;
   logic [N-1:0]    req_mem_ack_vld;
   logic [MW-1:0]   req_mem_rd_data;
   logic            mem_req_vld;
   logic [EW-1:0]   mem_addr;
   logic            mem_rd_en;
   logic            mem_wr_en;
   logic [MW-1:0]   mem_wr_data;
   logic [MW-1:0]   mem_rd_data = '0;
   logic            mem_ack_vld = 1'b0;
   logic            busy;
   logic [1:0]      grant_id;
   logic            timeout_err;

   snapshot_mem_arbiter #(
      .REQ_CNT(N), .ENTRY_WIDTH(EW), .MEM_WIDTH(MW), .TIMEOUT(TO), .TO_WIDTH(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_mem_req_vld(req_mem_req_vld), .req_mem_addr(req_mem_addr),
      .req_mem_rd_en(req_mem_rd_en), .req_mem_wr_en(req_mem_wr_en),
      .req_mem_wr_data(req_mem_wr_data), .req_mem_ack_vld(req_mem_ack_vld),
      .req_mem_rd_data(req_mem_rd_data), .mem_req_vld(mem_req_vld),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
      .mem_ack_vld(mem_ack_vld), .busy(busy), .grant_id(grant_id),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // kind: 0 = no enable (local completion), 1 = read, 2 = write
   typedef struct {
      int            id;
      int            kind;
      logic [EW-1:0] addr;
      logic [MW-1:0] wd;
   } acc_t;

   acc_t          exp_q[$];
   int            cfg_kind [N];
   logic [EW-1:0] cfg_addr [N];
   logic [MW-1:0] cfg_wd   [N];
   logic [MW-1:0] mem_model [128];

   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            cur_delay = 0;
   int            resp_cnt = -1;
   int            idle_cyc = 0;
   int            model_ptr = N-1;
   logic [MW-1:0] model_rd = '0;
   logic [MW-1:0] last_resp = '0;
   bit            access_active = 1'b0;
   bit            inject_ack = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [MW-1:0] rand36();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[MW-1:0];
   endfunction

   task automatic monitor();
      if (!rst_n) begin
         chk("rst_busy", 64'(busy), 64'(0));
         chk("rst_ack", 64'(req_mem_ack_vld), 64'(0));
         chk("rst_rd_data", 64'(req_mem_rd_data), 64'(0));
         chk("rst_grant", 64'(grant_id), 64'(0));
         chk("rst_to_err", 64'(timeout_err), 64'(0));
         chk("rst_mem_req", 64'(mem_req_vld), 64'(0));
         return;
      end
      if (exp_q.size() == 0) chk("idle_busy", 64'(busy), 64'(0));
      if (req_mem_ack_vld != '0) begin
         if (exp_q.size() == 0) begin
            chk("spurious_ack", 64'(req_mem_ack_vld), 64'(0));
         end else begin
            acc_t         e;
            bit           to;
            logic [N-1:0] oh;
            e  = exp_q.pop_front();
            to = (e.kind != 0) && (cur_delay < 0);
            if (to) model_rd = '0;
            else if (e.kind == 1) model_rd = last_resp;
            oh       = '0;
            oh[e.id] = 1'b1;
            chk("ack_vec", 64'(req_mem_ack_vld), 64'(oh));
            chk("grant_id", 64'(grant_id), 64'(e.id));
            chk("ack_rd_data", 64'(req_mem_rd_data), 64'(model_rd));
            chk("timeout_err", 64'(timeout_err), 64'(to));
            if (to)
               chk("to_latency_ok", 64'(cyc >= idle_cyc + 2 + TO && cyc <= idle_cyc + 3 + TO), 64'(1));
            else
               chk("latency", 64'(cyc), 64'(idle_cyc + ((e.kind == 0) ? 1 : 2 + cur_delay)));
            $display("ack req %0d kind %0d addr %h rd_data %h timeout %0d cycle %0d",
                     e.id, e.kind, e.addr, req_mem_rd_data, to, cyc);
            idle_cyc  = cyc + 1;
            model_ptr = e.id;
         end
         access_active = 1'b0;
      end else begin
         chk("rd_data_hold", 64'(req_mem_rd_data), 64'(model_rd));
         chk("no_to_err", 64'(timeout_err), 64'(0));
      end
      if (mem_req_vld) begin
         if (access_active || exp_q.size() == 0) begin
            chk("unexpected_mem_req", 64'(mem_req_vld), 64'(0));
         end else begin
            chk("mem_req_has_enable", 64'(exp_q[0].kind != 0), 64'(1));
            access_active = 1'b1;
         end
      end
      if (access_active)
         chk("mem_fields", 64'({mem_rd_en, mem_wr_en, mem_addr, mem_wr_data}),
             64'({exp_q[0].kind == 1, exp_q[0].kind == 2, exp_q[0].addr, exp_q[0].wd}));
      else
         chk("mem_idle_fields", 64'({mem_req_vld, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data}), 64'(0));
   endtask

   task automatic responder();
      mem_ack_vld = 1'b0;
      if (!rst_n) begin
         resp_cnt = -1;
         return;
      end
      if (inject_ack) begin
         mem_ack_vld = 1'b1;
         mem_rd_data = rand36();
         inject_ack  = 1'b0;
         return;
      end
      if (mem_req_vld) resp_cnt = cur_delay;
      if (resp_cnt == 0 && exp_q.size() != 0) begin
         mem_ack_vld = 1'b1;
         if (exp_q[0].kind == 1) begin
            last_resp   = mem_model[exp_q[0].addr];
            mem_rd_data = last_resp;
         end else begin
            mem_rd_data = rand36();
         end
         if (exp_q[0].kind == 2) mem_model[exp_q[0].addr] = exp_q[0].wd;
         resp_cnt = -1;
      end else if (resp_cnt > 0) begin
         resp_cnt--;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      req_mem_req_vld = '0;
      cyc++;
      monitor();
      responder();
   endtask

   task automatic set_cfg(input int i, input int kind, input logic [EW-1:0] addr, input logic [MW-1:0] wd);
      cfg_kind[i] = kind;
      cfg_addr[i] = addr;
      cfg_wd[i]   = wd;
   endtask

   task automatic start_round(input logic [N-1:0] mask, input int delay);
      cur_delay = delay;
      for (int i = 0; i < N; i++) begin
         req_mem_addr[i*EW +: EW]    = cfg_addr[i];
         req_mem_wr_data[i*MW +: MW] = cfg_wd[i];
         req_mem_rd_en[i]            = (cfg_kind[i] == 1);
         req_mem_wr_en[i]            = (cfg_kind[i] == 2);
      end
      idle_cyc = cyc + 1;
      for (int k = 1; k <= N; k++) begin
         acc_t a;
         int   idx;
         idx = (model_ptr + k) % N;
         if (mask[idx]) begin
            a.id = idx; a.kind = cfg_kind[idx]; a.addr = cfg_addr[idx]; a.wd = cfg_wd[idx];
            exp_q.push_back(a);
         end
      end
      req_mem_req_vld = mask;
   endtask

   task automatic finish_round();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
         cycle();
         budget++;
      end
      if (exp_q.size() != 0) begin
         chk("round_done", 64'(exp_q.size()), 64'(0));
         exp_q.delete();
         access_active = 1'b0;
      end
      cycle();
   endtask

   task automatic run_round(input logic [N-1:0] mask, input int delay, input logic [N-1:0] dup);
      start_round(mask, delay);
      cycle();
      req_mem_req_vld = dup;
      finish_round();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      for (int a = 0; a < 128; a++) mem_model[a] = rand36();
      for (int i = 0; i < N; i++) set_cfg(i, 0, '0, '0);
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;

      // Single read with a slow memory.
      mem_model[7'h15] = 36'hA_5A5A_5A5A;
      set_cfg(2, 1, 7'h15, rand36());
      run_round(4'b0100, 3, 4'b0000);
      chk("single_read_value", 64'(req_mem_rd_data), 64'(36'hA_5A5A_5A5A));

      // All four at once, then a wrap from 3 back to 0.
      for (int i = 0; i < N; i++) set_cfg(i, 1, EW'(i + 8), rand36());
      run_round(4'b1111, 0, 4'b0101);
      run_round(4'b1001, 0, 4'b0000);

      // Write, then a local completion.
      set_cfg(1, 2, 7'h30, 36'h1_2345_6789);
      run_round(4'b0010, 2, 4'b0000);
      set_cfg(3, 0, 7'h11, rand36());
      run_round(4'b1000, 0, 4'b0000);

      // Hung memory: both requests time out, then a late ack must be ignored.
      set_cfg(1, 1, 7'h05, rand36());
      set_cfg(2, 1, 7'h06, rand36());
      run_round(4'b0110, -1, 4'b0000);
      inject_ack = 1'b1;
      cycle();
      cycle();

      // Reset while waiting on memory; pointer must return to N-1.
      set_cfg(0, 1, 7'h03, rand36());
      run_round(4'b0001, 1, 4'b0000);
      set_cfg(1, 1, 7'h09, rand36());
      set_cfg(2, 2, 7'h0A, rand36());
      start_round(4'b0110, -1);
      begin
         int b;
         b = 0;
         while (!access_active && b < 20) begin
            cycle();
            b++;
         end
         chk("reached_wait", 64'(access_active), 64'(1));
      end
      cycle();
      cycle();
      rst_n = 1'b0;
      exp_q.delete();
      access_active = 1'b0;
      model_ptr = N-1;
      model_rd = '0;
      cycle();
      rst_n = 1'b1;
      repeat (8) cycle();
      set_cfg(0, 1, 7'h04, rand36());
      set_cfg(1, 1, 7'h0C, rand36());
      run_round(4'b0011, 1, 4'b0000);

      // Randomised rounds.
      repeat (40) begin
         logic [N-1:0] mask;
         logic [N-1:0] dup;
         int           d;
         mask = N'($urandom_range(1, 15));
         dup  = N'($urandom) & mask;
         d    = int'($urandom_range(0, 4));
         if ($urandom_range(0, 7) == 0) d = -1;
         for (int i = 0; i < N; i++)
            set_cfg(i, int'($urandom_range(0, 2)), EW'($urandom_range(0, 15)), rand36());
         run_round(mask, d, dup);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
